// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - shared opcode enum, opcode count and legality check for the logic unit
package logic_unit_pkg;

  localparam int LU_OP_NUM = 8;

  typedef enum logic [2:0] {
    LU_AND    = 3'd0,
    LU_NAND   = 3'd1,
    LU_OR     = 3'd2,
    LU_NOR    = 3'd3,
    LU_XOR    = 3'd4,
    LU_XNOR   = 3'd5,
    LU_NOT    = 3'd6,
    LU_PASS_B = 3'd7
  } lu_op_e;

  // Callers zero-extend their opcode to 32 bits so any OP_W can share this check.
  function automatic logic lu_is_legal(input logic [31:0] op);
    return op < 32'(LU_OP_NUM);
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// rtl/logic_unit_pipe_if.sv - operand/result handshake bundle; LOGIC_UNIT_PIPE_POPCNT_EN adds out_popcnt
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
  logic             out_err;
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
  logic [$clog2(WIDTH+1)-1:0] out_popcnt;
`endif

  // Upstream/downstream side (drives operands, accepts results)
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
    input  out_popcnt,
`endif
    input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity, out_err
  );

  // Pipeline side
  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
    output out_popcnt,
`endif
    output in_ready, out_valid, out_y, out_zero, out_ones, out_parity, out_err
  );

endinterface

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise function block: (a, b, op) -> (y, err)
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_y,
  output logic             o_err
);

  lu_op_e w_op;
  logic   w_legal;

  assign w_op    = lu_op_e'(i_op[2:0]);
  assign w_legal = lu_is_legal(32'(i_op));

  // Select the bitwise function; illegal codes force y to zero and raise err
  always_comb begin
    o_y   = '0;
    o_err = 1'b0;
    if (!w_legal) begin
      o_err = 1'b1;
    end else begin
      case (w_op)
        LU_AND:    o_y = i_a & i_b;
        LU_NAND:   o_y = ~(i_a & i_b);
        LU_OR:     o_y = i_a | i_b;
        LU_NOR:    o_y = ~(i_a | i_b);
        LU_XOR:    o_y = i_a ^ i_b;
        LU_XNOR:   o_y = ~(i_a ^ i_b);
        LU_NOT:    o_y = ~i_a;
        LU_PASS_B: o_y = i_b;
        default:   o_y = '0;
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready logic unit with result flags; LOGIC_UNIT_PIPE_POPCNT_EN adds popcount
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OP_W-1:0]  r_op;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_ones;
  logic             r_parity;
  logic             r_err;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [WIDTH-1:0] w_y;
  logic             w_err;

  // A stage may advance when it is empty or the stage after it is advancing;
  // in_ready never looks at in_valid.
  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign bus.in_ready = w_s1_adv;

  // S1: capture the operand beat on a handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_a  <= bus.in_a;
        r_b  <= bus.in_b;
        r_op <= bus.in_op;
      end
    end
  end

  logic_unit_core #(
    .WIDTH(WIDTH),
    .OP_W (OP_W)
  ) u_core (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_y  (w_y),
    .o_err(w_err)
  );

  // S2: register result and flags derived from the final y; payload holds unless a new beat arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
      r_zero     <= 1'b0;
      r_ones     <= 1'b0;
      r_parity   <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y      <= w_y;
        r_zero   <= (w_y == '0);
        r_ones   <= &w_y;
        r_parity <= ^w_y;
        r_err    <= w_err;
      end
    end
  end

`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
  localparam int PC_W = $clog2(WIDTH + 1);

  logic [PC_W-1:0] w_popcnt;
  logic [PC_W-1:0] r_popcnt;

  // Count the ones in the S2-bound result
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + PC_W'(w_y[i]);
    end
  end

  // Popcount register, loaded together with the other S2 flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_popcnt <= '0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_popcnt <= w_popcnt;
    end
  end

  assign bus.out_popcnt = r_popcnt;
`endif

  assign bus.out_valid  = r_s2_valid;
  assign bus.out_y      = r_y;
  assign bus.out_zero   = r_zero;
  assign bus.out_ones   = r_ones;
  assign bus.out_parity = r_parity;
  assign bus.out_err    = r_err;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard bench for logic_unit_pipe; LOGIC_UNIT_PIPE_POPCNT_EN also checks out_popcnt
module tb_logic_unit_pipe;

  localparam int W  = 8;
  localparam int OW = 4;

  typedef struct packed {
    logic [W-1:0] y;
    logic         zero;
    logic         ones;
    logic         parity;
    logic         err;
    int           popcnt;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W), .OP_W(OW)) bus ();

  logic_unit_pipe #(.WIDTH(W), .OP_W(OW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  exp_t   sbq[$];
  exp_t   e;
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  int     pushes   = 0;
  int     pops     = 0;
  bit     lat_chk  = 1'b0;
  bit     rnd_ready = 1'b0;
  bit     prev_stall = 1'b0;
  bit     prev_rst   = 1'b0;
  logic [W-1:0] prev_y;
  logic [3:0]   prev_flags;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: the eight bitwise functions and flags stated from the opcode table
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op);
    exp_t r;
    logic [W-1:0] all_ones;
    all_ones = '1;
    r = '0;
    case (int'(op))
      0: r.y = a & b;
      1: r.y = ~(a & b);
      2: r.y = a | b;
      3: r.y = ~(a | b);
      4: r.y = a ^ b;
      5: r.y = ~(a ^ b);
      6: r.y = ~a;
      7: r.y = b;
      default: begin r.y = '0; r.err = 1'b1; end
    endcase
    r.popcnt = $countones(r.y);
    r.zero   = (r.popcnt == 0);
    r.ones   = (r.y == all_ones);
    r.parity = (r.popcnt % 2) == 1;
    r.cyc    = cyc;
    return r;
  endfunction

  // Monitor: sample away from the rising edge, predict the handshakes of the coming edge
  always @(negedge clk) begin
    cyc++;
    if (prev_rst) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_y", bus.out_y, 0);
      chk("rst_flags", {bus.out_zero, bus.out_ones, bus.out_parity, bus.out_err}, 0);
      chk("rst_in_ready", bus.in_ready, 1);
    end
    if (prev_stall) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_y", bus.out_y, prev_y);
      chk("stall_flags", {bus.out_zero, bus.out_ones, bus.out_parity, bus.out_err}, prev_flags);
    end
    if (rst) begin
      sbq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got y=%0h expected no beat (t=%0t)", bus.out_y, $time);
        end else begin
          e = sbq.pop_front();
          chk("y", bus.out_y, e.y);
          chk("err", bus.out_err, e.err);
          chk("zero", bus.out_zero, e.zero);
          chk("ones", bus.out_ones, e.ones);
          chk("parity", bus.out_parity, e.parity);
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
          chk("popcnt", bus.out_popcnt, e.popcnt);
`endif
          if (lat_chk) chk("latency", cyc - e.cyc, 2);
          pops++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sbq.push_back(model(bus.in_a, bus.in_b, bus.in_op));
        pushes++;
      end
    end
    prev_stall = !rst && bus.out_valid && !bus.out_ready;
    prev_y     = bus.out_y;
    prev_flags = {bus.out_zero, bus.out_ones, bus.out_parity, bus.out_err};
    prev_rst   = rst;
  end

  task automatic rnd_out_ready();
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one beat, hold it until accepted; returns the number of stalled cycles
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op, output int waits);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    bus.in_valid = 1'b1;
    waits = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rnd_out_ready();
        return;
      end
      waits++;
      @(posedge clk);
      #1;
      rnd_out_ready();
    end
    chk("send_timeout", 1, 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 100 && sbq.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    int w;
    int base_push;
    int base_pop;
    logic [7:0] tmp;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // All eight functions back-to-back, one beat per cycle, fixed latency
    lat_chk = 1'b1;
    for (int op = 0; op < 8; op++) begin
      send(8'hF0, 8'h3C, OW'(op), w);
      chk("b2b_no_wait", w, 0);
    end
    send(8'hAA, 8'h55, 4'd0, w);
    send(8'h00, 8'h00, 4'd3, w);
    send(8'h01, 8'h00, 4'd4, w);
    send(8'hFF, 8'hFF, 4'd9, w);
    send(8'h12, 8'h34, 4'd2, w);
    send(8'h5A, 8'hA5, 4'd15, w);
    send(8'h5A, 8'hA5, 4'd5, w);
    wait_empty();
    lat_chk = 1'b0;

    // Back-pressure: out_ready low for 4 cycles while 5 beats are streamed
    base_push = pushes;
    base_pop  = pops;
    bus.out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_accepted", pushes - base_push, 2);
        chk("bp_in_ready", bus.in_ready, 0);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          tmp = 8'($urandom);
          send(tmp, 8'(i * 17), OW'(i), w);
        end
      end
    join
    wait_empty();
    chk("bp_delivered", pops - base_pop, 5);

    // Reset with two beats in flight: they must never appear
    base_pop = pops;
    bus.out_ready = 1'b0;
    send(8'h11, 8'h22, 4'd2, w);
    send(8'h33, 8'h44, 4'd4, w);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_phantom", pops - base_pop, 0);

    // Randomised traffic with random back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 8'($urandom), OW'($urandom_range(0, 15)), w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        rnd_out_ready();
      end
    end
    rnd_ready = 1'b0;
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
